// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the 5-stage pipeline datapath and the hazard/trap
// sequencer. All signals are plain per-cycle levels with no valid/ready pairs.
// The only request/response pair is irq (a level held by the peripherals) and
// irq_ack (a single-cycle pulse issued in the cycle the interrupt is taken).
interface pipeline_hazard_ctrl_if;
    // Hazard and trap sources coming from the datapath
    logic       id_ex_memrd;
    logic [4:0] id_ex_rt;
    logic [4:0] if_id_rs;
    logic [4:0] if_id_rt;
    logic       if_id_uses_rt;
    logic       ex_branch_taken;
    logic       id_jump;
    logic       id_exception;
    logic       kernel_mode;
    logic       irq;

    // Pipeline control driven back into the datapath
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic [2:0] pc_ovr;
    logic       epc_capture;
    logic       irq_ack;
    logic       in_guard;

    // Datapath side: supplies the hazard sources, consumes the controls
    modport master (
        output id_ex_memrd, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt,
               ex_branch_taken, id_jump, id_exception, kernel_mode, irq,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, pc_ovr,
               epc_capture, irq_ack, in_guard
    );

    // Sequencer side
    modport slave (
        input  id_ex_memrd, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt,
               ex_branch_taken, id_jump, id_exception, kernel_mode, irq,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, pc_ovr,
               epc_capture, irq_ack, in_guard
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/trap sequencer for the 5-stage MIPS pipeline.
// Resolves load-use, taken-branch and jump hazards, schedules interrupt and
// exception entry, and holds off interrupts for a guard window after a trap
// so that kernel mode has time to reach ID. in_guard exposes the FSM state.
module pipeline_hazard_ctrl #(
    parameter int GUARD_CYCLES = 3   // legal range 1..15
) (
    input  logic                         clk,
    input  logic                         reset,   // asynchronous, active-low
    pipeline_hazard_ctrl_if.slave        bus
);

    typedef enum logic {
        RUN   = 1'b0,
        GUARD = 1'b1
    } state_t;

    localparam logic [2:0] OVR_NONE = 3'd0;
    localparam logic [2:0] OVR_IRQ  = 3'd4;  // ILLOP interrupt vector
    localparam logic [2:0] OVR_EXC  = 3'd5;  // XADR exception vector
    localparam logic [3:0] GUARD_INIT = 4'(GUARD_CYCLES - 1);

    state_t     state, state_nx;
    logic [3:0] guard_cnt, guard_cnt_nx;
    logic       irq_pend, irq_pend_nx;

    logic       load_use;
    logic       int_take;
    logic       take_irq;

    // Load in EX whose destination is read by the instruction in ID ($0 never hazards)
    always_comb begin
        load_use = bus.id_ex_memrd && (bus.id_ex_rt != 5'd0) &&
                   ((bus.id_ex_rt == bus.if_id_rs) ||
                    (bus.if_id_uses_rt && (bus.id_ex_rt == bus.if_id_rt)));
        int_take = (state == RUN) && irq_pend && !bus.kernel_mode && !load_use;
    end

    // State, guard counter and pending-interrupt latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            guard_cnt <= 4'd0;
            irq_pend  <= 1'b0;
        end else begin
            state     <= state_nx;
            guard_cnt <= guard_cnt_nx;
            irq_pend  <= irq_pend_nx;
        end
    end

    // Priority resolution of hazards/traps plus next-state logic
    always_comb begin
        bus.pc_write    = 1'b1;
        bus.if_id_write = 1'b1;
        bus.if_id_flush = 1'b0;
        bus.id_ex_flush = 1'b0;
        bus.pc_ovr      = OVR_NONE;
        bus.epc_capture = 1'b0;
        bus.irq_ack     = 1'b0;
        bus.in_guard    = (state == GUARD);
        state_nx        = state;
        guard_cnt_nx    = guard_cnt;
        take_irq        = 1'b0;

        // Guard window countdown; a new trap below overrides it
        if (state == GUARD) begin
            if (guard_cnt == 4'd0) begin
                state_nx = RUN;
            end else begin
                guard_cnt_nx = guard_cnt - 4'd1;
            end
        end

        if (bus.ex_branch_taken) begin
            // Anything in ID is wrong-path, including a trap it would raise
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (bus.id_exception) begin
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
            bus.pc_ovr      = OVR_EXC;
            bus.epc_capture = 1'b1;
            state_nx        = GUARD;
            guard_cnt_nx    = GUARD_INIT;
        end else if (int_take) begin
            // A jump in ID is flushed too; EPC holds it so it re-executes
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
            bus.pc_ovr      = OVR_IRQ;
            bus.epc_capture = 1'b1;
            bus.irq_ack     = 1'b1;
            take_irq        = 1'b1;
            state_nx        = GUARD;
            guard_cnt_nx    = GUARD_INIT;
        end else if (load_use) begin
            // Single bubble: the bubble clears id_ex_memrd next cycle
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
            bus.id_ex_flush = 1'b1;
        end else if (bus.id_jump) begin
            bus.if_id_flush = 1'b1;
        end

        // Taking the interrupt clears the latch even if irq is still high
        if (take_irq) begin
            irq_pend_nx = 1'b0;
        end else begin
            irq_pend_nx = irq_pend || bus.irq;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: inputs change 1 ns after the
// rising edge, expected output vectors are queued and compared on the
// falling edge.
module tb_pipeline_hazard_ctrl;

    logic clk;
    logic reset;

    pipeline_hazard_ctrl_if hz();

    pipeline_hazard_ctrl #(.GUARD_CYCLES(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hz)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector: {pc_write, if_id_write, if_id_flush, id_ex_flush, pc_ovr[2:0], epc_capture, irq_ack, in_guard}
    localparam logic [9:0] DEF   = 10'b11_00_000_0_0_0;
    localparam logic [9:0] GRD   = 10'b11_00_000_0_0_1;
    localparam logic [9:0] STALL = 10'b00_01_000_0_0_0;
    localparam logic [9:0] BRF   = 10'b11_11_000_0_0_0;
    localparam logic [9:0] JMP   = 10'b11_10_000_0_0_0;
    localparam logic [9:0] EXC   = 10'b11_11_101_1_0_0;
    localparam logic [9:0] EXC_G = 10'b11_11_101_1_0_1;
    localparam logic [9:0] INT   = 10'b11_11_100_1_1_0;

    logic [9:0] exp_q[$];
    string      tag_q[$];
    int         vectors;
    int         miscompares;

    function automatic logic [9:0] observed();
        return {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_flush,
                hz.pc_ovr, hz.epc_capture, hz.irq_ack, hz.in_guard};
    endfunction

    // Scoreboard: pop the oldest expectation and compare with the DUT now
    task automatic compare();
        logic [9:0] e;
        logic [9:0] o;
        string      t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = observed();
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", t, o, e);
        end
    endtask

    // Driver: queue expectation, check at falling edge, advance to next drive point
    task automatic step(input string tag, input logic [9:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string tag, input logic [9:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        compare();
    endtask

    task automatic idle_inputs();
        hz.id_ex_memrd     = 1'b0;
        hz.id_ex_rt        = 5'd0;
        hz.if_id_rs        = 5'd0;
        hz.if_id_rt        = 5'd0;
        hz.if_id_uses_rt   = 1'b0;
        hz.ex_branch_taken = 1'b0;
        hz.id_jump         = 1'b0;
        hz.id_exception    = 1'b0;
        hz.kernel_mode     = 1'b0;
        hz.irq             = 1'b0;
    endtask

    task automatic guard_run(input string tag);
        for (int i = 0; i < 3; i++) step(tag, GRD);
    endtask

    initial begin
        logic [4:0] r;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        idle_inputs();

        #1;
        check_now("reset_state", DEF);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step("after_reset", DEF);

        // Load-use via rs, then the bubble clears memrd
        r = 5'($urandom_range(1, 31));
        hz.id_ex_memrd = 1'b1; hz.id_ex_rt = r; hz.if_id_rs = r;
        step("lu_rs_stall", STALL);
        hz.id_ex_memrd = 1'b0;
        step("lu_rs_release", DEF);

        // Load-use via rt only counts when ID reads rt
        r = 5'($urandom_range(1, 31));
        hz.id_ex_memrd = 1'b1; hz.id_ex_rt = r; hz.if_id_rs = 5'd0;
        hz.if_id_rt = r; hz.if_id_uses_rt = 1'b1;
        step("lu_rt_stall", STALL);
        hz.if_id_uses_rt = 1'b0;
        step("lu_rt_unused", DEF);

        // $0 destination never stalls
        hz.id_ex_rt = 5'd0; hz.if_id_rs = 5'd0; hz.if_id_rt = 5'd0; hz.if_id_uses_rt = 1'b1;
        step("lu_r0", DEF);
        idle_inputs();

        // Branch beats exception; no trap, state stays RUN
        hz.ex_branch_taken = 1'b1; hz.id_exception = 1'b1;
        step("branch_over_exc", BRF);
        idle_inputs();
        step("branch_no_guard", DEF);

        hz.id_jump = 1'b1;
        step("jump_flush", JMP);
        idle_inputs();

        // Exception entry then a full guard window
        hz.id_exception = 1'b1;
        step("exc_entry", EXC);
        idle_inputs();
        guard_run("exc_guard");
        step("exc_guard_end", DEF);

        // User-mode interrupt, one-cycle irq pulse; jump in ID is flushed with it
        hz.irq = 1'b1;
        step("irq_latch", DEF);
        hz.irq = 1'b0; hz.id_jump = 1'b1;
        step("irq_take", INT);
        idle_inputs();
        guard_run("irq_guard");
        step("irq_guard_end", DEF);

        // Kernel mode blocks the take for as long as it lasts
        hz.irq = 1'b1; hz.kernel_mode = 1'b1;
        for (int i = 0; i < 10; i++) step("irq_kernel_block", DEF);
        hz.irq = 1'b0; hz.kernel_mode = 1'b0;
        step("irq_kernel_release", INT);
        guard_run("irq_k_guard");
        step("irq_k_guard_end", DEF);

        // Load-use delays the take by exactly one cycle
        hz.irq = 1'b1; hz.kernel_mode = 1'b1;
        step("irq_lu_latch", DEF);
        hz.irq = 1'b0; hz.kernel_mode = 1'b0;
        r = 5'($urandom_range(1, 31));
        hz.id_ex_memrd = 1'b1; hz.id_ex_rt = r; hz.if_id_rs = r;
        step("irq_lu_stall", STALL);
        idle_inputs();
        step("irq_lu_take", INT);
        guard_run("irq_lu_guard");
        step("irq_lu_guard_end", DEF);

        // Exception on the 2nd guard cycle restarts guard; irq waits for RUN
        hz.id_exception = 1'b1;
        step("g_exc1", EXC);
        hz.id_exception = 1'b0; hz.irq = 1'b1;
        step("g_irq_in_guard", GRD);
        hz.irq = 1'b0; hz.id_exception = 1'b1;
        step("g_exc2", EXC_G);
        idle_inputs();
        guard_run("g_restart");
        step("g_irq_first_run", INT);
        guard_run("g_irq_guard");
        step("g_irq_guard_end", DEF);

        // Async reset mid-guard with an interrupt pending
        hz.id_exception = 1'b1;
        step("rst_exc", EXC);
        hz.id_exception = 1'b0; hz.irq = 1'b1;
        step("rst_guard_irq", GRD);
        hz.irq = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_now("rst_async_defaults", DEF);
        @(posedge clk);
        #1;
        check_now("rst_held", DEF);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step("rst_no_stale_irq", DEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/trap sequencer for the 5-stage MIPS pipeline.
- Detects load-use, taken-branch and jump hazards and drives PC write-enable, IF/ID write/flush and ID/EX flush.
- Schedules interrupt and exception entry by overriding PC source and pulsing EPC capture.
- A guard window after each trap blocks re-entry until kernel mode has propagated.

Parameters:
GUARD_CYCLES, 3, cycles after a trap during which interrupts are not taken (legal range 1..15).

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous active-low reset
id_ex_memrd  in  1  instruction in EX is a load
id_ex_rt  in  5  load destination register in EX
if_id_rs  in  5  rs of instruction in ID
if_id_rt  in  5  rt of instruction in ID
if_id_uses_rt  in  1  ID instruction reads rt
ex_branch_taken  in  1  branch in EX resolved taken
id_jump  in  1  J/JAL/JR/JALR decoded in ID
id_exception  in  1  undefined instruction decoded in ID
kernel_mode  in  1  PC[31] of instruction in ID
irq  in  1  level interrupt request from peripherals
pc_write  out  1  PC register enable
if_id_write  out  1  IF/ID register enable
if_id_flush  out  1  IF/ID converted to bubble
id_ex_flush  out  1  ID/EX Flush input
pc_ovr  out  3  0 none, 4 interrupt vector (ILLOP), 5 exception vector (XADR)
epc_capture  out  1  save PC of the flushed ID instruction into EPC ($26)
irq_ack  out  1  one-cycle interrupt acknowledge
in_guard  out  1  state == GUARD

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-low.
- State on reset: state=RUN, irq_pend=0, guard_cnt=0.
- Outputs are combinational from state, registers and inputs. Default/reset values: pc_write=1, if_id_write=1, flushes=0, pc_ovr=0, epc_capture=0, irq_ack=0, in_guard=0.
- load_use = id_ex_memrd & (id_ex_rt!=0) & ((id_ex_rt==if_id_rs) | (if_id_uses_rt & id_ex_rt==if_id_rt)).
- irq_pend: set at the clock edge when irq=1; cleared at the edge of an interrupt take. Clear wins over set.
- Per-cycle priority, evaluated in both states. Only the highest active row applies.
  1. ex_branch_taken: if_id_flush=1, id_ex_flush=1. Any exception or interrupt in ID is wrong-path and is discarded.
  2. id_exception: if_id_flush=1, id_ex_flush=1, pc_ovr=5, epc_capture=1. Next state GUARD, guard_cnt=GUARD_CYCLES-1 (restarts if already in GUARD).
  3. int_take = (state==RUN) & irq_pend & ~kernel_mode & ~load_use: if_id_flush=1, id_ex_flush=1, pc_ovr=4, epc_capture=1, irq_ack=1. Next state GUARD, guard_cnt=GUARD_CYCLES-1, irq_pend cleared. A simultaneous id_jump is flushed; EPC points at the jump so it re-executes.
  4. load_use: pc_write=0, if_id_write=0, id_ex_flush=1. Exactly one bubble, because the bubble clears id_ex_memrd on the next cycle.
  5. id_jump: if_id_flush=1.
- GUARD state:
  - Interrupts are never taken; irq_pend still sets.
  - Branch, exception, load-use and jump rows still apply.
  - guard_cnt decrements each cycle; on the cycle guard_cnt==0, next state is RUN.
  - GUARD lasts exactly GUARD_CYCLES cycles absent a new exception.
- kernel_mode=1 blocks interrupt take indefinitely; irq_pend is held until a user-mode instruction reaches ID.
- Reset asserted mid-GUARD or mid-stall: immediate return to reset values, no pending interrupt retained.

Test Plan:
- Load-use: lw $8 in EX (memrd=1, rt=8), ID rs=8 -> one cycle pc_write=0, if_id_write=0, id_ex_flush=1; next cycle memrd=0 -> all defaults. Repeat with rt=0 -> no stall.
- Branch vs exception: ex_branch_taken=1 with id_exception=1 -> both flushes=1, pc_ovr=0, epc_capture=0, state stays RUN.
- Interrupt in user mode: irq pulse 1 cycle, kernel_mode=0 -> next cycle pc_ovr=4, irq_ack=1, epc_capture=1, both flushes. in_guard=1 for exactly 3 cycles, then 0.
- Interrupt blocked: irq=1 while kernel_mode=1 for 10 cycles -> no irq_ack. kernel_mode falls -> irq_ack on that cycle. Same with load_use=1 -> irq_ack delayed one cycle.
- Exception in GUARD: id_exception on 2nd guard cycle -> pc_ovr=5; guard restarts; in_guard stays 1 for 3 further cycles; an irq arriving during guard is taken on the first RUN cycle.
- Async reset: assert reset low mid-guard between clock edges with irq_pend=1 -> outputs return to defaults immediately; after release no irq_ack without a new irq.
